// File: rtl/unified_mem_arbiter_pkg.sv
// unified_mem_arbiter_pkg: shared widths, arbiter states and RAM response type
package unified_mem_arbiter_pkg;
   localparam int ADDR_W = 64;
   localparam int DATA_W = 64;
   localparam int F_BEATS = 3;
   localparam int MAX_M_STREAK = 4;
   localparam int BEAT_BYTES = 8;
   localparam int F_LINE_W = F_BEATS * DATA_W;
   localparam int BEAT_W = $clog2(F_BEATS);
   localparam int STREAK_W = $clog2(MAX_M_STREAK + 1);
   typedef enum logic [1:0] {IDLE, M_ACC, F_ACC, F_DRAIN} arb_state_t;
   typedef struct packed {
      logic ack;
      logic err;
   } mem_rsp_t;
   function automatic logic [ADDR_W-1:0] beat_base(input logic [ADDR_W-1:0] addr);
      return addr & ~ADDR_W'(BEAT_BYTES - 1);
   endfunction
endpackage

// File: rtl/unified_mem_arbiter_if.sv
// unified_mem_arbiter_if: fetch, data and RAM handshake bundle; slave is the arbiter, master its environment
interface unified_mem_arbiter_if;
   import unified_mem_arbiter_pkg::*;
   logic f_req_i;
   logic [ADDR_W-1:0] f_addr_i;
   logic f_flush_i;
   logic f_rdy_o;
   logic [F_LINE_W-1:0] f_line_o;
   logic f_err_o;
   logic f_wait_o;
   logic m_req_i;
   logic m_we_i;
   logic [ADDR_W-1:0] m_addr_i;
   logic [DATA_W-1:0] m_wdata_i;
   logic m_rdy_o;
   logic [DATA_W-1:0] m_rdata_o;
   logic m_err_o;
   logic m_wait_o;
   logic mem_req_o;
   logic mem_we_o;
   logic [ADDR_W-1:0] mem_addr_o;
   logic [DATA_W-1:0] mem_wdata_o;
   logic mem_ack_i;
   logic [DATA_W-1:0] mem_rdata_i;
   logic mem_err_i;
   modport slave (
      input f_req_i, f_addr_i, f_flush_i, m_req_i, m_we_i, m_addr_i, m_wdata_i,
      input mem_ack_i, mem_rdata_i, mem_err_i,
      output f_rdy_o, f_line_o, f_err_o, f_wait_o, m_rdy_o, m_rdata_o, m_err_o, m_wait_o,
      output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o
   );
   modport master (
      output f_req_i, f_addr_i, f_flush_i, m_req_i, m_we_i, m_addr_i, m_wdata_i,
      output mem_ack_i, mem_rdata_i, mem_err_i,
      input f_rdy_o, f_line_o, f_err_o, f_wait_o, m_rdy_o, m_rdata_o, m_err_o, m_wait_o,
      input mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o
   );
endinterface

// File: rtl/unified_mem_arbiter_fetch_line_buf.sv
// fetch_line_buf: counts fetch beats and assembles the line; beats never written stay zero
module fetch_line_buf
   import unified_mem_arbiter_pkg::*;
(
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                start_i,
   input  logic                ack_i,
   input  logic                err_i,
   input  logic [DATA_W-1:0]   rdata_i,
   output logic [F_LINE_W-1:0] line_o,
   output logic                last_o
);
   logic [BEAT_W-1:0] beat_q, beat_d;
   logic [F_LINE_W-1:0] line_q, line_d;
   always_comb begin
      beat_d = start_i ? '0 : (ack_i && !err_i) ? beat_q + 1'b1 : beat_q;
      line_d = start_i ? '0 : line_q;
      if (ack_i && !err_i) line_d[beat_q*DATA_W +: DATA_W] = rdata_i;
   end
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         beat_q <= '0;
         line_q <= '0;
      end else begin
         beat_q <= beat_d;
         line_q <= line_d;
      end
   end
   assign line_o = line_q;
   assign last_o = beat_q == BEAT_W'(F_BEATS - 1);
endmodule

// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter: shares one variable-latency RAM between fetch line reads and data accesses
module unified_mem_arbiter
   import unified_mem_arbiter_pkg::*;
(
   input logic clk_i,
   input logic rst_i,
   unified_mem_arbiter_if.slave bus
);
   arb_state_t state_q, state_d;
   logic hold_q, hold_d;
   logic [STREAK_W-1:0] streak_q, streak_d;
   logic mem_req_q, mem_req_d, mem_we_q, mem_we_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d, m_rdata_q, m_rdata_d;
   logic m_rdy_q, m_rdy_d, m_err_q, m_err_d, f_rdy_q, f_rdy_d, f_err_q, f_err_d;
   logic m_win, f_win, f_ack, f_last, f_done, m_done, acc_done;
   mem_rsp_t rsp;
   assign rsp = '{ack: bus.mem_ack_i, err: bus.mem_err_i};
   // hold_q blanks arbitration for the cycle a completion is visible, so a still-held request is not re-granted
   always_comb begin
      m_win = state_q == IDLE && !hold_q && bus.m_req_i && !(bus.f_req_i && streak_q == STREAK_W'(MAX_M_STREAK));
      f_win = state_q == IDLE && !hold_q && !m_win && bus.f_req_i && !bus.f_flush_i;
      m_done = state_q == M_ACC && rsp.ack;
      f_ack = state_q == F_ACC && rsp.ack && !bus.f_flush_i;
      f_done = f_ack && (rsp.err || f_last);
      acc_done = m_done || f_done || (rsp.ack && (state_q == F_DRAIN || (state_q == F_ACC && bus.f_flush_i)));
      state_d = m_win ? M_ACC : f_win ? F_ACC : acc_done ? IDLE : (state_q == F_ACC && bus.f_flush_i) ? F_DRAIN : state_q;
      hold_d = acc_done;
      streak_d = (!bus.f_req_i || f_win) ? '0 : m_win ? streak_q + 1'b1 : streak_q;
      mem_req_d = m_win || f_win || (mem_req_q && !acc_done);
      mem_we_d = m_win ? bus.m_we_i : f_win ? 1'b0 : mem_we_q;
      mem_addr_d = m_win ? bus.m_addr_i : f_win ? beat_base(bus.f_addr_i) : f_ack ? mem_addr_q + ADDR_W'(BEAT_BYTES) : mem_addr_q;
      mem_wdata_d = m_win ? bus.m_wdata_i : mem_wdata_q;
      m_rdy_d = m_done;
      m_err_d = m_done && rsp.err;
      m_rdata_d = (m_done && !mem_we_q) ? bus.mem_rdata_i : m_rdata_q;
      f_rdy_d = f_done;
      f_err_d = f_done && rsp.err;
   end
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         hold_q <= 1'b0;
         streak_q <= '0;
         mem_req_q <= 1'b0;
         mem_we_q <= 1'b0;
         mem_addr_q <= '0;
         mem_wdata_q <= '0;
         m_rdy_q <= 1'b0;
         m_err_q <= 1'b0;
         m_rdata_q <= '0;
         f_rdy_q <= 1'b0;
         f_err_q <= 1'b0;
      end else begin
         state_q <= state_d;
         hold_q <= hold_d;
         streak_q <= streak_d;
         mem_req_q <= mem_req_d;
         mem_we_q <= mem_we_d;
         mem_addr_q <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         m_rdy_q <= m_rdy_d;
         m_err_q <= m_err_d;
         m_rdata_q <= m_rdata_d;
         f_rdy_q <= f_rdy_d;
         f_err_q <= f_err_d;
      end
   end
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         assert (state_q != M_ACC || bus.m_req_i);
         assert (state_q != F_ACC || bus.f_req_i || bus.f_flush_i);
      end
   end
   fetch_line_buf u_buf (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .start_i (f_win),
      .ack_i   (f_ack),
      .err_i   (rsp.err),
      .rdata_i (bus.mem_rdata_i),
      .line_o  (bus.f_line_o),
      .last_o  (f_last)
   );
   assign bus.mem_req_o = mem_req_q;
   assign bus.mem_we_o = mem_we_q;
   assign bus.mem_addr_o = mem_addr_q;
   assign bus.mem_wdata_o = mem_wdata_q;
   assign bus.m_rdy_o = m_rdy_q;
   assign bus.m_err_o = m_err_q;
   assign bus.m_rdata_o = m_rdata_q;
   assign bus.f_rdy_o = f_rdy_q;
   assign bus.f_err_o = f_err_q;
   assign bus.f_wait_o = bus.f_req_i & ~f_rdy_q;
   assign bus.m_wait_o = bus.m_req_i & ~m_rdy_q;
endmodule

// File: tb/tb_unified_mem_arbiter.sv
// tb_unified_mem_arbiter: directed checks of arbitration, line fetch, flush, wrap/error and reset
module tb_unified_mem_arbiter;
   import unified_mem_arbiter_pkg::*;
   logic clk = 0;
   logic rst = 1;
   int checks = 0;
   int failures = 0;
   always #5 clk = ~clk;
   unified_mem_arbiter_if bus();
   unified_mem_arbiter dut (.clk_i(clk), .rst_i(rst), .bus(bus.slave));
   logic [63:0] mem [logic [63:0]];
   logic [63:0] ack_log [$];
   logic ram_en = 1, err_en = 0, ram_ack = 0, ram_err = 0, man_ack = 0;
   logic [63:0] ram_rdata = 0, man_rdata = 0, err_addr = 0;
   int wait_cyc = 0, cnt = 0, f_rdy_cnt = 0, m_rdy_cnt = 0;
   logic [63:0] exp4 [9] = '{64'h1000, 64'h1008, 64'h1010, 64'h1018, 64'h2000, 64'h2008, 64'h2010, 64'h1020, 64'h1028};
   assign bus.mem_ack_i = ram_en ? ram_ack : man_ack;
   assign bus.mem_rdata_i = ram_en ? ram_rdata : man_rdata;
   assign bus.mem_err_i = ram_en && ram_err;
   function automatic logic [63:0] rd(input logic [63:0] a);
      return mem.exists(a) ? mem[a] : (a ^ 64'h5A5A_0000_0000_0000);
   endfunction
   // RAM model: acks after wait_cyc idle cycles per beat, updated mid-cycle
   always @(negedge clk) begin
      ram_ack = 0;
      ram_err = 0;
      if (ram_en && bus.mem_req_o && !rst) begin
         if (cnt >= wait_cyc) begin
            ram_ack = 1;
            ram_rdata = rd(bus.mem_addr_o);
            ram_err = err_en && bus.mem_addr_o == err_addr;
            if (bus.mem_we_o) mem[bus.mem_addr_o] = bus.mem_wdata_o;
            ack_log.push_back(bus.mem_addr_o);
            cnt = 0;
         end else cnt++;
      end else cnt = 0;
      if (bus.f_rdy_o) f_rdy_cnt++;
      if (bus.m_rdy_o) m_rdy_cnt++;
   end
   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask
   task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   task automatic wait_m_rdy(input string tag);
      int n = 0;
      do begin
         step(1);
         if (bus.f_rdy_o) bus.f_req_i = 0;
         n++;
      end while (bus.m_rdy_o !== 1'b1 && n < 40);
      chk(tag, bus.m_rdy_o, 1);
   endtask
   task automatic wait_f_rdy(input string tag);
      int n = 0;
      do begin
         step(1);
         n++;
      end while (bus.f_rdy_o !== 1'b1 && n < 40);
      chk(tag, bus.f_rdy_o, 1);
   endtask
   initial begin
      int n;
      int fr;
      bus.f_req_i = 0; bus.f_addr_i = 0; bus.f_flush_i = 0;
      bus.m_req_i = 0; bus.m_we_i = 0; bus.m_addr_i = 0; bus.m_wdata_i = 0;
      mem[64'h100] = 64'hDEAD;
      step(2);
      chk("rst_mem_req", bus.mem_req_o, 0);
      chk("rst_rdy", {bus.f_rdy_o, bus.m_rdy_o, bus.f_err_o, bus.m_err_o}, 0);
      chk("rst_line", bus.f_line_o, 0);
      chk("rst_rdata", bus.m_rdata_o, 0);
      rst = 0;
      step(1);
      // data read, zero-wait RAM
      bus.m_req_i = 1; bus.m_addr_i = 64'h100;
      step(1);
      chk("rd_mem_req", bus.mem_req_o, 1);
      chk("rd_mem_addr", bus.mem_addr_o, 64'h100);
      chk("rd_m_wait", bus.m_wait_o, 1);
      step(1);
      chk("rd_m_rdy", bus.m_rdy_o, 1);
      chk("rd_rdata", bus.m_rdata_o, 64'hDEAD);
      chk("rd_m_wait_low", bus.m_wait_o, 0);
      chk("rd_mem_req_low", bus.mem_req_o, 0);
      bus.m_req_i = 0;
      step(1);
      chk("rd_rdy_pulse", bus.m_rdy_o, 0);
      chk("rd_rdata_held", bus.m_rdata_o, 64'hDEAD);
      // data write leaves read data alone
      bus.m_req_i = 1; bus.m_we_i = 1; bus.m_addr_i = 64'h200; bus.m_wdata_i = 64'h1234;
      step(1);
      chk("wr_we", bus.mem_we_o, 1);
      chk("wr_wdata", bus.mem_wdata_o, 64'h1234);
      step(1);
      chk("wr_m_rdy", bus.m_rdy_o, 1);
      chk("wr_rdata_kept", bus.m_rdata_o, 64'hDEAD);
      bus.m_req_i = 0; bus.m_we_i = 0;
      // unaligned fetch with 2-wait RAM
      ack_log.delete();
      wait_cyc = 2; fr = f_rdy_cnt;
      bus.f_req_i = 1; bus.f_addr_i = 64'h0B;
      step(1);
      chk("f2_wait", bus.f_wait_o, 1);
      wait_f_rdy("f2_rdy");
      chk("f2_line", bus.f_line_o, {rd(64'h18), rd(64'h10), rd(64'h08)});
      chk("f2_err", bus.f_err_o, 0);
      bus.f_req_i = 0;
      chk("f2_nbeats", ack_log.size(), 3);
      chk("f2_addr0", ack_log[0], 64'h08);
      chk("f2_addr1", ack_log[1], 64'h10);
      chk("f2_addr2", ack_log[2], 64'h18);
      step(2);
      chk("f2_rdy_once", f_rdy_cnt - fr, 1);
      // simultaneous fetch and data: data first
      ack_log.delete();
      wait_cyc = 0;
      bus.f_req_i = 1; bus.f_addr_i = 64'h43;
      bus.m_req_i = 1; bus.m_addr_i = 64'h300;
      step(1);
      chk("both_data_first", bus.mem_addr_o, 64'h300);
      wait_m_rdy("both_m_rdy");
      bus.m_req_i = 0;
      wait_f_rdy("both_f_rdy");
      bus.f_req_i = 0;
      chk("both_fetch_addr", ack_log[1], 64'h40);
      chk("both_nbeats", ack_log.size(), 4);
      step(2);
      // six data requests against a waiting fetch
      ack_log.delete();
      fr = f_rdy_cnt;
      bus.f_req_i = 1; bus.f_addr_i = 64'h2000;
      for (int i = 0; i < 6; i++) begin
         bus.m_addr_i = 64'h1000 + 64'(8 * i); bus.m_req_i = 1;
         wait_m_rdy("streak_m_rdy");
      end
      bus.m_req_i = 0;
      chk("streak_nbeats", ack_log.size(), 9);
      for (int i = 0; i < 9; i++) chk("streak_order", ack_log[i], exp4[i]);
      chk("streak_fetch_once", f_rdy_cnt - fr, 1);
      step(2);
      // flush during beat 1 with 3-wait RAM
      ack_log.delete();
      wait_cyc = 3; fr = f_rdy_cnt;
      bus.f_req_i = 1; bus.f_addr_i = 64'h500;
      n = 0;
      while (ack_log.size() < 1 && n < 40) begin step(1); n++; end
      chk("fl_beat0", ack_log.size(), 1);
      bus.f_flush_i = 1; bus.f_req_i = 0;
      step(1);
      bus.f_flush_i = 0;
      chk("fl_state", dut.state_q, F_DRAIN);
      chk("fl_req_held", bus.mem_req_o, 1);
      chk("fl_f_wait", bus.f_wait_o, 0);
      n = 0;
      while (bus.mem_req_o && n < 40) begin step(1); n++; end
      chk("fl_drained", bus.mem_req_o, 0);
      chk("fl_drain_ack", ack_log.size(), 2);
      chk("fl_idle", dut.state_q, IDLE);
      step(1);
      chk("fl_no_rdy", f_rdy_cnt - fr, 0);
      // address wrap, zero-wait latency
      ack_log.delete();
      wait_cyc = 0;
      bus.f_req_i = 1; bus.f_addr_i = 64'hFFFF_FFFF_FFFF_FFF8;
      step(3);
      chk("wrap_early", bus.f_rdy_o, 0);
      step(1);
      chk("wrap_rdy", bus.f_rdy_o, 1);
      chk("wrap_line", bus.f_line_o, {rd(64'h8), rd(64'h0), rd(64'hFFFF_FFFF_FFFF_FFF8)});
      chk("wrap_addr1", ack_log[1], 64'h0);
      chk("wrap_addr2", ack_log[2], 64'h8);
      bus.f_req_i = 0;
      step(2);
      // error on beat 1 stops the line
      ack_log.delete();
      err_en = 1; err_addr = 64'h0;
      bus.f_req_i = 1;
      step(3);
      chk("err_rdy", bus.f_rdy_o, 1);
      chk("err_flag", bus.f_err_o, 1);
      chk("err_line", bus.f_line_o, {128'h0, rd(64'hFFFF_FFFF_FFFF_FFF8)});
      chk("err_nbeats", ack_log.size(), 2);
      bus.f_req_i = 0; err_en = 0;
      step(1);
      chk("err_pulse", bus.f_err_o, 0);
      step(1);
      // reset in the middle of a data access, then a stale ack
      ram_en = 0;
      bus.m_req_i = 1; bus.m_addr_i = 64'h100;
      step(1);
      chk("rst_mid_req", bus.mem_req_o, 1);
      rst = 1;
      step(1);
      rst = 0; bus.m_req_i = 0;
      chk("rst_mid_drop", bus.mem_req_o, 0);
      chk("rst_mid_idle", dut.state_q, IDLE);
      man_ack = 1; man_rdata = 64'hBEEF;
      step(1);
      man_ack = 0;
      step(1);
      chk("stale_no_rdy", bus.m_rdy_o, 0);
      chk("stale_rdata", bus.m_rdata_o, 0);
      chk("stale_no_req", bus.mem_req_o, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
